// File: rtl/viol_log_pkg.sv
// Shared types and default widths for the setup-violation logger.
package viol_log_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } log_state_e;

  localparam int DEF_TS_W  = 16;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/viol_evt_fifo.sv
// Register FIFO of violation timestamps; push-while-full is accepted only with a same-cycle pop.
module viol_evt_fifo
  import viol_log_pkg::*;
#(
  parameter int W     = DEF_TS_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/setup_viol_logger.sv
// Synchronizes a toggling timing-check notifier, timestamps each toggle and queues it for a host.
module setup_viol_logger
  import viol_log_pkg::*;
#(
  parameter int TS_W        = DEF_TS_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter bit STOP_ON_OVF = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             notifier,
  input  logic             arm,
  input  logic             disarm,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [TS_W-1:0]  ev_ts,
  output logic [CNT_W-1:0] viol_count,
  output logic             overflow,
  output logic [1:0]       state_o
);

  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [TS_W-1:0]  r_ts;
  log_state_e       r_state;
  log_state_e       w_next_state;
  logic [CNT_W-1:0] r_viol_count;
  logic             r_overflow;
  logic             w_toggle;
  logic             w_event;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic             w_arm_clear;

  assign w_toggle    = r_s2 ^ r_s3;
  assign w_event     = w_toggle && (r_state == ARMED);
  assign ev_valid    = !w_empty;
  assign w_pop       = ev_valid && ev_ready;
  assign w_push      = w_event && (!w_full || w_pop);
  assign w_drop      = w_event && w_full && !w_pop;
  assign w_arm_clear = (r_state == IDLE) && arm && !disarm;

  assign viol_count = r_viol_count;
  assign overflow   = r_overflow;
  assign state_o    = r_state;

  // s1 is the metastability stage; toggles are only judged between s2 and s3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_ts <= '0;
    end else begin
      r_s1 <= notifier;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_ts <= r_ts + TS_ONE;
    end
  end

  // Disarm always wins, even over a stop-on-overflow drop in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (arm && !disarm) w_next_state = ARMED;
        else                w_next_state = IDLE;
      end
      ARMED: begin
        if (disarm)                     w_next_state = IDLE;
        else if (w_drop && STOP_ON_OVF) w_next_state = HALTED;
        else                            w_next_state = ARMED;
      end
      HALTED: begin
        if (disarm) w_next_state = IDLE;
        else        w_next_state = HALTED;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_viol_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_arm_clear) begin
        r_viol_count <= '0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_event && (r_viol_count != '1)) r_viol_count <= r_viol_count + CNT_ONE;
        if (w_drop)                          r_overflow   <= 1'b1;
      end
    end
  end

  viol_evt_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_ts),
    .i_pop   (w_pop),
    .o_data  (ev_ts),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
